// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the shift-add multiplier sequencer.
package mult_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

   // Iteration counter must hold 0..n.
   function automatic int unsigned cnt_width(int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_sequencer_adder.sv
// Plain n-bit unsigned adder; the sequencer's only arithmetic element.
module adder #(
   parameter int n = 32
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic [n-1:0] s
);

   always_comb s = a + b;

endmodule

// File: rtl/mult_sequencer.sv
// Unsigned shift-add multiplier: one shared adder iterated n times,
// start/ready/done handshake, product held until the next accepted start.
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int n = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] product
);

   localparam int unsigned CW = cnt_width(n);

   mult_state_t   state_q, state_d;
   logic [n-1:0]  mcand_q, mcand_d;
   logic [n-1:0]  hi_q, hi_d;
   logic [n-1:0]  lo_q, lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [n:0]    addend;
   logic [n:0]    sum;

   always_comb addend = lo_q[0] ? {1'b0, mcand_q} : '0;

   adder #(.n(n + 1)) u_adder (
      .a ({1'b0, hi_q}),
      .b (addend),
      .s (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = a;
               lo_d    = b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Carry out of sum is always 0, so the shifted-in bit is sum[n].
            hi_d  = sum[n:1];
            lo_d  = {sum[0], lo_q[n-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(n - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (state_q)
         IDLE:    ready = 1'b1;
         RUN:     busy  = 1'b1;
         DONE:    done  = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_comb product = {hi_q, lo_q};

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (n=32) against a timeline/arithmetic model.
module tb_mult_sequencer;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  a, b;
   logic          ready, busy, done;
   logic [2*N-1:0] product;

   int vectors     = 0;
   int miscompares = 0;
   int n_done      = 0;

   mult_sequencer #(.n(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Model: an accepted op is busy for N cycles, then done for one, then idle.
   bit          m_active;
   int          m_age;
   logic [63:0] m_pend, m_prod;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_prod   <= '0;
         m_pend   <= '0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_age    <= 0;
            m_pend   <= 64'(a) * 64'(b);
         end
      end else begin
         if (m_age == N - 1) m_prod <= m_pend;
         if (m_age == N) m_active <= 1'b0;
         m_age <= m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("ready", 64'(ready), 64'(!m_active));
         chk("busy",  64'(busy),  64'(m_active && m_age < N));
         chk("done",  64'(done),  64'(m_active && m_age == N));
         if (!(m_active && m_age < N)) chk("product", product, m_prod);
         if (done) n_done++;
      end
   end

   task automatic issue(input logic [N-1:0] aa, input logic [N-1:0] bb);
      @(posedge clk); #2;
      start = 1'b1; a = aa; b = bb;
      @(posedge clk); #2;
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   // Counts cycles after the accepting edge until done; optional stray starts.
   task automatic watch(input int pulse_at, input bit pulse_done,
                        output int lat, output int bcnt, output logic [63:0] prod);
      bit seen = 1'b0;
      lat = 0; bcnt = 0; prod = '0;
      for (int k = 1; k <= 100 && !seen; k++) begin
         @(negedge clk); #1;
         if (busy) bcnt++;
         if (k == pulse_at) begin start = 1'b1; a = 2; b = 2; end
         else if (k == pulse_at + 1) start = 1'b0;
         if (done) begin
            seen = 1'b1; lat = k; prod = product;
            if (pulse_done) begin
               start = 1'b1; a = 2; b = 2;
               @(negedge clk); #1;
               start = 1'b0;
            end
         end
      end
      chk("done_seen", 64'(seen), 64'd1);
   endtask

   int          lat, bcnt, snap, last_k, cnt_d;
   logic [63:0] prod;

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_done",  64'(done),  64'd0);
      chk("rst_product", product, 64'd0);
      #23 rst_n = 1'b1;

      issue(32'd3, 32'd5);
      watch(0, 1'b0, lat, bcnt, prod);
      chk("3x5_latency", 64'(lat), 64'd33);
      chk("3x5_busy_cycles", 64'(bcnt), 64'd32);
      chk("3x5_product", prod, 64'd15);
      @(negedge clk); #1;
      chk("3x5_ready_after", 64'(ready), 64'd1);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      watch(0, 1'b0, lat, bcnt, prod);
      chk("max_product", prod, 64'hFFFF_FFFE_0000_0001);

      issue(32'h1234_5678, 32'd0);
      watch(0, 1'b0, lat, bcnt, prod);
      chk("bzero_product", prod, 64'd0);
      chk("bzero_latency", 64'(lat), 64'd33);

      issue(32'd0, 32'h9ABC_DEF0);
      watch(0, 1'b0, lat, bcnt, prod);
      chk("azero_product", prod, 64'd0);
      chk("azero_latency", 64'(lat), 64'd33);

      @(negedge clk);
      snap = n_done;
      issue(32'd7, 32'd9);
      watch(10, 1'b1, lat, bcnt, prod);
      chk("7x9_product", prod, 64'd63);
      chk("7x9_latency", 64'(lat), 64'd33);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("7x9_hold", product, 64'd63);
         chk("7x9_idle_ready", 64'(ready), 64'd1);
      end
      chk("7x9_one_done", 64'(n_done - snap), 64'd1);

      issue(32'd11, 32'd13);
      repeat (16) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_busy",  64'(busy),  64'd0);
      chk("abort_done",  64'(done),  64'd0);
      chk("abort_product", product, 64'd0);
      #10 rst_n = 1'b1;
      snap = n_done;
      repeat (40) @(negedge clk);
      chk("abort_no_done", 64'(n_done - snap), 64'd0);
      issue(32'd6, 32'd7);
      watch(0, 1'b0, lat, bcnt, prod);
      chk("6x7_product", prod, 64'd42);

      @(posedge clk); #2;
      start = 1'b1; a = 32'hFFFF_0000; b = 32'h0001_0000;
      last_k = 0; cnt_d = 0;
      for (int k = 1; k <= 200 && cnt_d < 3; k++) begin
         @(negedge clk); #1;
         if (done) begin
            chk("stream_product", product, 64'h0000_FFFF_0000_0000);
            if (cnt_d > 0) chk("stream_spacing", 64'(k - last_k), 64'd34);
            last_k = k;
            cnt_d++;
         end
      end
      chk("stream_count", 64'(cnt_d), 64'd3);
      start = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle unsigned shift-add multiplier controller that sequences one shared `adder` instance over n iterations to form a 2n-bit product. It sits beside the ALU and gives the datapath a multiply path without a combinational array multiplier. The block has a start/ready/done handshake and holds its result until the next accepted operation.

## Interface
Parameters:
- `n`, default 32: operand width in bits, with n ≥ 2.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request to begin. Sampled only while `ready`=1.
- `a`, input, n: multiplicand. Captured on the accepting edge.
- `b`, input, n: multiplier. Captured on the accepting edge.
- `ready`, output, 1: high when the block is idle and can accept `start`.
- `busy`, output, 1: high while iterations are in progress.
- `done`, output, 1: one-cycle pulse; `product` is valid.
- `product`, output, 2n: unsigned a×b. Held stable until the next accepted start.

## Operation
- Registers:
  - `mcand` (n bits)
  - `hi` (n bits)
  - `lo` (n bits, initially the multiplier)
  - `cnt` ($clog2(n+1) bits)
  - `state`
- FSM states:
  - IDLE: `ready`=1. On `start`=1, load `mcand`←a, `lo`←b, `hi`←0, `cnt`←0, and go to RUN.
  - RUN: `busy`=1. Each edge does one iteration and increments `cnt`. When the iteration with `cnt`=n-1 completes, go to DONE.
  - DONE: `done`=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Iteration, using the (n+1)-bit adder:
  - sum = {1'b0,hi} + (lo[0] ? {1'b0,mcand} : 0).
  - {hi,lo} ← {sum,lo} >> 1, i.e. hi←sum[n:1] and lo←{sum[0],lo[n-1:1]}.
  - The carry out of the (n+1)-bit sum is always 0, so no overflow is possible.
- `product` = {hi,lo}. It is driven from registers, not from the adder.
- Latency is fixed at n iterations. There is no early termination for zero or small operands.
- `start` in RUN or DONE is ignored and does not queue.
- `a` and `b` may change freely after the accepting edge.
- Reset (asynchronous, at any time, including mid-RUN):
  - state→IDLE; `mcand`, `hi`, `lo`, `cnt` → 0.
  - Output values: `ready`=1, `busy`=0, `done`=0, `product`=0.
  - The aborted operation produces no `done`.

## Timing
- Accepting edge E0: `start`=1 and state=IDLE.
- From E0 to E0+n: state=RUN, `busy`=1, `ready`=0.
- Edges E1…En perform iterations 0…n-1. Edge En moves to DONE.
- Between En and En+1: `done`=1, `busy`=0, `ready`=0, `product` final.
- Edge En+1: back to IDLE, `ready`=1. The earliest next accept is edge En+2, so back-to-back issue spacing is n+2 cycles.
- `product` holds its final value from En through the next accepting edge. It changes during RUN and is valid only while `done`=1 or in IDLE after a completed operation.
- `ready`, `busy`, `done` are decoded from registered state only, with no combinational path from `start`.

## Structure
- Package `mult_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t`
  - localparam helper for the counter width, $clog2(n+1).
- One sub-module: the existing `adder` instantiated with parameter n+1 as the sole arithmetic element. The FSM, shift registers and counter stay in `mult_sequencer`.

## Test plan
- n=32, a=3, b=5, start for one cycle:
  - `busy` high for 32 cycles.
  - `done` pulses exactly 33 cycles after the accepting edge with `product`=15.
  - `ready` returns the following cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF → `product`=0xFFFFFFFE_00000001 at `done`.
- a=0x12345678, b=0 and a=0, b=0x9ABCDEF0 → `product`=0, with latency still 33 cycles.
- Start 7×9. Pulse `start` with a=2, b=2 at cycle 10 of RUN and again during DONE:
  - Exactly one `done`, with `product`=63.
  - `product` holds 63 through the subsequent IDLE cycles.
- Assert `rst_n`=0 asynchronously mid-RUN (cycle 16):
  - Outputs immediately become `ready`=1, `busy`=0, `done`=0, `product`=0.
  - After release, 6×7 completes normally with 42.
- Hold `start`=1 continuously with a=0xFFFF0000, b=0x10000:
  - Operations are accepted every 34 cycles.
  - Each `done` shows `product`=0xFFFF_00000000.
